// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if
//   Bundles the requester-side and transmitter-side signals of the
//   uart_tx_arbiter.
//   Requester side:
//     req      - per-requester level request
//     req_data - packed bytes; requester i at [i*DATA_W +: DATA_W]
//     req_ack  - one-cycle pulse when a requester's frame completes
//     req_err  - one-cycle pulse when a requester's frame times out
//   Transmitter side (towards uart_tx):
//     start_tx - one-cycle launch pulse
//     data_tx  - byte, held stable for the whole frame
//     tx_done  - completion pulse from uart_tx
//   Modports: master = arbiter, slave = requesters + transmitter.
interface uart_tx_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 8
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_ack;
  logic [NUM_REQ-1:0]        req_err;
  logic                      start_tx;
  logic [DATA_W-1:0]         data_tx;
  logic                      tx_done;

  modport master (
    input  req, req_data, tx_done,
    output req_ack, req_err, start_tx, data_tx
  );

  modport slave (
    output req, req_data, tx_done,
    input  req_ack, req_err, start_tx, data_tx
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Round-robin arbiter/sequencer sharing one uart_tx between NUM_REQ byte
//   requesters, with a watchdog that recovers from a transmitter that never
//   reports tx_done.
//   Ports:
//     clk          - system clock, rising edge
//     rst_n        - asynchronous active-low reset
//     bus          - uart_tx_arbiter_if.master (req/ack/err and uart_tx side)
//     timeout_clr  - synchronous clear of timeout_flag (a new timeout wins)
//     busy         - high whenever the FSM is not IDLE
//     grant_id     - index of the current or last granted requester
//     timeout_flag - sticky, set on any timeout
//   All outputs are registered.
module uart_tx_arbiter #(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = 8,
  parameter int TIMEOUT_CYCLES = 65535,
  parameter int GAP_CYCLES     = 2,
  localparam int IDW           = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  uart_tx_arbiter_if.master    bus,
  input  logic                 timeout_clr,
  output logic                 busy,
  output logic [IDW-1:0]       grant_id,
  output logic                 timeout_flag
);

  localparam int CNT_W = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = NUM_REQ'(1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_WAIT   = 2'd2,
    S_GAP    = 2'd3
  } state_t;

  state_t              state_reg;
  logic [CNT_W-1:0]    cnt_reg;
  logic [GAP_W-1:0]    gap_reg;
  logic [IDW-1:0]      last_grant_reg;
  logic [IDW-1:0]      grant_id_reg;
  logic [DATA_W-1:0]   data_tx_reg;
  logic                start_tx_reg;
  logic [NUM_REQ-1:0]  req_ack_reg;
  logic [NUM_REQ-1:0]  req_err_reg;
  logic                busy_reg;
  logic                timeout_flag_reg;

  // Per-requester view of the packed data bus.
  logic [DATA_W-1:0] req_bytes [NUM_REQ];

  generate
    for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
      assign req_bytes[gi] = bus.req_data[gi*DATA_W +: DATA_W];
    end
  endgenerate

  // Round-robin pick: scan offsets NUM_REQ..1 from last_grant so that the
  // smallest offset with a pending request is the one left standing.
  // Offset NUM_REQ is last_grant itself, so a lone requester is still served.
  logic           sel_valid;
  logic [IDW-1:0] sel_idx;
  logic [IDW-1:0] cand;
  int             cand_int;

  always_comb begin
    sel_valid = 1'b0;
    sel_idx   = '0;
    cand      = '0;
    cand_int  = 0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      cand_int = int'(last_grant_reg) + k;
      if (cand_int >= NUM_REQ) cand_int = cand_int - NUM_REQ;
      cand = IDW'(cand_int);
      if (bus.req[cand]) begin
        sel_valid = 1'b1;
        sel_idx   = cand;
      end
    end
  end

  // Single FSM; every output is a register updated alongside the state.
  // Watchdog: cnt_reg is 0 in the first WAIT cycle, so the terminal count is
  // seen on the TIMEOUT_CYCLES-th WAIT cycle and req_err is visible the cycle
  // after, exactly like req_ack follows tx_done.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg        <= S_IDLE;
      cnt_reg          <= '0;
      gap_reg          <= '0;
      last_grant_reg   <= IDW'(NUM_REQ - 1);
      grant_id_reg     <= '0;
      data_tx_reg      <= '0;
      start_tx_reg     <= 1'b0;
      req_ack_reg      <= '0;
      req_err_reg      <= '0;
      busy_reg         <= 1'b0;
      timeout_flag_reg <= 1'b0;
    end else begin
      start_tx_reg <= 1'b0;
      req_ack_reg  <= '0;
      req_err_reg  <= '0;
      // A timeout set later in this block overrides this clear.
      if (timeout_clr) timeout_flag_reg <= 1'b0;

      case (state_reg)
        S_IDLE: begin
          if (sel_valid) begin
            grant_id_reg <= sel_idx;
            data_tx_reg  <= req_bytes[sel_idx];
            start_tx_reg <= 1'b1;
            busy_reg     <= 1'b1;
            state_reg    <= S_LAUNCH;
          end
        end

        S_LAUNCH: begin
          cnt_reg   <= '0;
          state_reg <= S_WAIT;
        end

        S_WAIT: begin
          if (bus.tx_done || (cnt_reg == CNT_TERM)) begin
            // Done takes priority over a simultaneous terminal count.
            if (bus.tx_done) begin
              req_ack_reg <= ONE_HOT0 << grant_id_reg;
            end else begin
              req_err_reg      <= ONE_HOT0 << grant_id_reg;
              timeout_flag_reg <= 1'b1;
            end
            last_grant_reg <= grant_id_reg;
            gap_reg        <= '0;
            if (GAP_CYCLES == 0) begin
              state_reg <= S_IDLE;
              busy_reg  <= 1'b0;
            end else begin
              state_reg <= S_GAP;
            end
          end else if (cnt_reg != '1) begin
            cnt_reg <= cnt_reg + CNT_W'(1);
          end
        end

        S_GAP: begin
          if (gap_reg == GAP_LAST) begin
            state_reg <= S_IDLE;
            busy_reg  <= 1'b0;
          end else begin
            gap_reg <= gap_reg + GAP_W'(1);
          end
        end

        default: begin
          state_reg <= S_IDLE;
          busy_reg  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.start_tx = start_tx_reg;
  assign bus.data_tx  = data_tx_reg;
  assign bus.req_ack  = req_ack_reg;
  assign bus.req_err  = req_err_reg;
  assign busy         = busy_reg;
  assign grant_id     = grant_id_reg;
  assign timeout_flag = timeout_flag_reg;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter
//   Directed bench for uart_tx_arbiter (NUM_REQ=4, DATA_W=8,
//   TIMEOUT_CYCLES=100, GAP_CYCLES=2). Expected grants are queued when
//   requests are driven and popped when the arbiter launches a frame; the
//   transmitter is modelled by pulsing tx_done a chosen number of WAIT
//   cycles after launch.
module tb_uart_tx_arbiter;

  localparam int NR   = 4;
  localparam int DW   = 8;
  localparam int TO   = 100;
  localparam int GAP  = 2;
  localparam int FRM  = 30;

  logic       clk;
  logic       rst_n;
  logic       timeout_clr;
  logic       busy;
  logic [1:0] grant_id;
  logic       timeout_flag;

  uart_tx_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW)) bus ();

  uart_tx_arbiter #(
    .NUM_REQ(NR), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .GAP_CYCLES(GAP)
  ) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .timeout_clr(timeout_clr),
    .busy(busy), .grant_id(grant_id), .timeout_flag(timeout_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int        id;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  int         total = 0;
  int         bad   = 0;
  int         cur_id;
  logic [7:0] cur_data;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_req(input int id, input logic [7:0] d);
    bus.req_data[id*DW +: DW] = d;
    bus.req[id] = 1'b1;
  endtask

  task automatic expect_grant(input int id, input logic [7:0] d);
    exp_t e;
    e.id = id;
    e.data = d;
    sb.push_back(e);
  endtask

  // Waits (bounded) for the launch cycle and checks it against the scoreboard.
  task automatic wait_launch();
    exp_t e;
    int n = 0;
    while (bus.start_tx !== 1'b1 && n < 10) begin
      tick();
      n++;
    end
    check("launch_seen", 32'(bus.start_tx), 32'd1);
    if (sb.size() == 0) begin
      check("scoreboard_empty", 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      cur_id = e.id;
      cur_data = e.data;
      check("grant_id", 32'(grant_id), 32'(e.id));
      check("data_tx", 32'(bus.data_tx), 32'(e.data));
      check("busy_launch", 32'(busy), 32'd1);
    end
  endtask

  // Runs wait_cycles WAIT cycles, pulses tx_done in the last, checks the ack.
  task automatic finish_frame(input int wait_cycles, input bit drop);
    for (int i = 0; i < wait_cycles; i++) begin
      tick();
      if (i == 0) check("start_one_pulse", 32'(bus.start_tx), 32'd0);
    end
    check("data_hold", 32'(bus.data_tx), 32'(cur_data));
    bus.tx_done = 1'b1;
    tick();
    bus.tx_done = 1'b0;
    check("req_ack", 32'(bus.req_ack), 32'd1 << cur_id);
    check("req_err_none", 32'(bus.req_err), 32'd0);
    $display("txn id=%0d data=%02h ack=%b err=%b", cur_id, bus.data_tx, bus.req_ack, bus.req_err);
    if (drop) bus.req[cur_id] = 1'b0;
    tick();
    check("ack_pulse_end", 32'(bus.req_ack), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_start"}, 32'(bus.start_tx), 32'd0);
    check({tag, "_ack"}, 32'(bus.req_ack), 32'd0);
    check({tag, "_err"}, 32'(bus.req_err), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_flag"}, 32'(timeout_flag), 32'd0);
    check({tag, "_data"}, 32'(bus.data_tx), 32'd0);
    check({tag, "_grant"}, 32'(grant_id), 32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

  initial begin
    rst_n = 1'b0;
    timeout_clr = 1'b0;
    bus.req = '0;
    bus.req_data = '0;
    bus.tx_done = 1'b0;
    repeat (3) tick();
    check_reset_outputs("reset");
    rst_n = 1'b1;
    tick();

    // Single request.
    drive_req(0, 8'h55);
    expect_grant(0, 8'h55);
    wait_launch();
    finish_frame(FRM, 1'b1);
    tick();
    check("busy_after_gap", 32'(busy), 32'd0);

    // Fresh reset so requester 0 has priority, then all four at once.
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < NR; i++) begin
      drive_req(i, 8'hA0 + 8'(i));
      expect_grant(i, 8'hA0 + 8'(i));
    end
    for (int i = 0; i < NR; i++) begin
      wait_launch();
      finish_frame(FRM, 1'b1);
    end

    // Fairness: req[0] held, req[2] arrives mid-frame.
    drive_req(0, 8'h10);
    expect_grant(0, 8'h10);
    wait_launch();
    repeat (5) tick();
    drive_req(2, 8'h22);
    expect_grant(2, 8'h22);
    expect_grant(0, 8'h10);
    finish_frame(FRM - 5, 1'b0);
    wait_launch();
    finish_frame(FRM, 1'b1);
    wait_launch();
    finish_frame(FRM, 1'b1);

    // Timeout: tx_done never comes.
    drive_req(1, 8'h77);
    expect_grant(1, 8'h77);
    wait_launch();
    for (int i = 0; i < TO; i++) tick();
    check("err_not_early", 32'(bus.req_err), 32'd0);
    tick();
    check("req_err_timeout", 32'(bus.req_err), 32'b0010);
    check("ack_none_timeout", 32'(bus.req_ack), 32'd0);
    check("flag_set", 32'(timeout_flag), 32'd1);
    $display("txn id=%0d data=%02h ack=%b err=%b", cur_id, bus.data_tx, bus.req_ack, bus.req_err);
    bus.req[1] = 1'b0;
    drive_req(2, 8'h33);
    expect_grant(2, 8'h33);
    wait_launch();
    finish_frame(FRM, 1'b1);
    check("flag_sticky", 32'(timeout_flag), 32'd1);
    timeout_clr = 1'b1;
    tick();
    timeout_clr = 1'b0;
    check("flag_cleared", 32'(timeout_flag), 32'd0);

    // tx_done on the terminal-count cycle: done wins.
    drive_req(3, 8'h99);
    expect_grant(3, 8'h99);
    wait_launch();
    finish_frame(TO, 1'b1);
    check("flag_after_terminal", 32'(timeout_flag), 32'd0);

    // Asynchronous reset in the middle of WAIT.
    drive_req(0, 8'h5A);
    expect_grant(0, 8'h5A);
    wait_launch();
    repeat (10) tick();
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_outputs("async_rst");
    bus.req = '0;
    drive_req(3, 8'hC3);
    expect_grant(3, 8'hC3);
    tick();
    tick();
    rst_n = 1'b1;
    wait_launch();
    finish_frame(FRM, 1'b1);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
